mix_columns_sched: RTL and testbench

MIX_COLUMNS_SCHED -- requirements
Module: mix_columns_sched

---
 rtl/mix_columns_sched.sv | 118 +++++++++++
 tb/tb_mix_columns_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_sched.sv
// AES MixColumns engine with one shared 32-bit column mixer, one column per cycle.
// Optional InvMixColumns support is built when INV_MIXCOL_EN is defined (adds port inv).
module mix_columns_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIXCOL_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q;
  logic [127:0]  st_q;
  logic [127:0]  res_q;
  logic          init_q;
  logic          inv_sel;
  logic          accept;
  logic [31:0]   col_in;
  logic [31:0]   col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: sum of x, 2x, 4x, 8x selected by the bits of c.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

`ifdef INV_MIXCOL_EN
  logic inv_q;
  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  assign in_ready  = init_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == COMP) || (state_q == DONE);
  assign out_data  = res_q;
  assign accept    = in_valid && in_ready;
  assign col_in    = st_q[{col_q, 5'b0} +: 32];

  // Single column mixer; row r uses coefficient k[(j - r) mod 4] for input byte j.
  always_comb begin
    logic [7:0] b [4];
    logic [3:0] k [4];
    logic [7:0] r [4];
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    col_out = 32'h0;
    for (int j = 0; j < 4; j++) b[j] = col_in[31-8*j -: 8];
    if (inv_sel) begin
      k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
    end else begin
      k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
    end
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gmul(b[j], k[(j - i) & 3]);
    end
    col_out = {r[0], r[1], r[2], r[3]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COMP;
      COMP:    if (col_q == 2'd0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      st_q    <= '0;
      res_q   <= '0;
      init_q  <= 1'b0;
`ifdef INV_MIXCOL_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        st_q  <= in_data;
        col_q <= 2'd3;
`ifdef INV_MIXCOL_EN
        inv_q <= inv;
`endif
      end else if (state_q == COMP) begin
        res_q[{col_q, 5'b0} +: 32] <= col_out;
        col_q <= col_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_sched.sv
// Scoreboard bench for mix_columns_sched: directed vectors, latency, backpressure, reset abort,
// back-to-back throughput, and the inverse transform when INV_MIXCOL_EN is defined.
module tb_mix_columns_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] data;
    time          t_acc;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V2_IN  = 128'hc6c6c6c6_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] V2_OUT = 128'hc6c6c6c6_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] V3_IN  = 128'h2d26314c_01010101_f20a225c_db135345;
  localparam logic [127:0] V3_OUT = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;

  always #5 clk = ~clk;

  mix_columns_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef INV_MIXCOL_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Present one state, wait (bounded) for the accept edge, and push the expected result.
  task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] e,
                      input bit hold, output time t_acc);
    logic rdy;
    bit   ok;
    ok = 0;
    t_acc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    inv      = iv;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) ok = 1;
    end
    if (ok) begin
      t_acc = $time;
      sb.push_back('{data: e, t_acc: t_acc});
    end else begin
      check("accept_timeout", 128'd0, 128'd1);
    end
    if (!hold) begin
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) check("drain_timeout", 128'd0, 128'd1);
  endtask

  // Monitor: first cycle of out_valid checks latency and data, later cycles check stability.
  bit active = 0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 128'd1, 128'd0);
      end else begin
        if (!active) begin
          check("latency_ns_after_accept", 128'($time - sb[0].t_acc), 128'd45);
          check("out_data", out_data, sb[0].data);
          active = 1;
        end else begin
          check("out_data_stable", out_data, sb[0].data);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          active = 0;
        end
      end
    end
  end

  initial begin
    time t0, t1, t2;

    // Reset state
    #3;
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_out_data",  out_data,        128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", 128'(in_ready), 128'd1);

    // Forward vector and identity-style columns
    send(V1_IN, 1'b0, V1_OUT, 0, t0);
    wait_drain();
    send(V2_IN, 1'b0, V2_OUT, 0, t0);
    @(negedge clk);
    check("busy_in_comp",     128'(busy),      128'd1);
    check("out_valid_in_comp", 128'(out_valid), 128'd0);
    check("in_ready_in_comp", 128'(in_ready),  128'd0);
    wait_drain();

    // Backpressure: hold out_ready low 10 cycles while offering a new state
    out_ready = 1'b0;
    send(V3_IN, 1'b0, V3_OUT, 0, t0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_out_valid_seen", 128'(out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = V1_IN;
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready),  128'd0);
      check("bp_out_valid",    128'(out_valid), 128'd1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid_dropped", 128'(out_valid), 128'd0);
    check("bp_in_ready_back",     128'(in_ready),  128'd1);
    wait_drain();

    // Reset during COMP aborts the operation
    send(V1_IN, 1'b0, V1_OUT, 0, t0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy",      128'(busy),      128'd0);
    check("abort_in_ready",  128'(in_ready),  128'd0);
    check("abort_out_data",  out_data,        128'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", 128'(out_valid), 128'd0);
    end
    check("abort_in_ready_after", 128'(in_ready), 128'd1);

    // Back-to-back with in_valid held high
    send(V1_IN, 1'b0, V1_OUT, 1, t0);
    send(V2_IN, 1'b0, V2_OUT, 1, t1);
    send(V3_IN, 1'b0, V3_OUT, 0, t2);
    check("b2b_spacing_1", 128'(t1 - t0), 128'd60);
    check("b2b_spacing_2", 128'(t2 - t1), 128'd60);
    wait_drain();

`ifdef INV_MIXCOL_EN
    send(V1_OUT, 1'b1, V1_IN, 0, t0);
    wait_drain();
    send(V2_OUT, 1'b1, V2_IN, 0, t0);
    wait_drain();
    send(V1_IN, 1'b0, V1_OUT, 0, t0);
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
